// File: rtl/uart_tx_fifo.sv
// Transmit FIFO ahead of the UART TX controller: first-word-fall-through head,
// registered status, sticky overflow/underflow. Watermark flags: UART_TX_FIFO_WATERMARK_EN.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    read,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clear_errors
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_nxt;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  ovf_set;
    logic                  unf_set;

    // A full FIFO still takes a write when the same cycle frees the head slot.
    assign wr_accept = write & (~full | read);
    assign rd_accept = read & ~empty;
    assign ovf_set   = write & full & ~read;
    assign unf_set   = read & empty;

    always_comb begin
        count_nxt = count;
        if (wr_accept && !rd_accept) begin
            count_nxt = count + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CNT_W'(DEPTH));

            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clear_errors) begin
                overflow <= 1'b0;
            end

            if (unf_set) begin
                underflow <= 1'b1;
            end else if (clear_errors) begin
                underflow <= 1'b0;
            end
        end
    end

    // Storage is intentionally left out of reset; empty masks stale contents.
    always_ff @(posedge clk) begin
        if (!reset && wr_accept) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

`ifdef UART_TX_FIFO_WATERMARK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_nxt >= CNT_W'(AF_LEVEL));
            almost_empty <= (count_nxt <= CNT_W'(AE_LEVEL));
        end
    end
`else
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;
`ifdef UART_TX_FIFO_WATERMARK_EN
    localparam bit WM = 1'b1;
`else
    localparam bit WM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          write = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          read = 1'b0;
    logic          clear_errors = 1'b0;
    logic [DW-1:0] rdata;
    logic          empty, full, almost_full, almost_empty, overflow, underflow;
    logic [4:0]    count;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] q[$];
    logic          m_ov = 1'b0;
    logic          m_un = 1'b0;

    uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .reset(reset), .write(write), .wdata(wdata), .read(read),
        .rdata(rdata), .empty(empty), .full(full), .count(count),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow), .clear_errors(clear_errors)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] m_head();
        return (q.size() > 0) ? q[0] : '0;
    endfunction

    function automatic logic m_af();
        return WM && (q.size() >= AF);
    endfunction

    function automatic logic m_ae();
        return WM && (q.size() <= AE);
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model, settle.
    task automatic step(input logic rs, input logic w, input logic [DW-1:0] d,
                        input logic r, input logic c);
        logic m_full, m_empty, wacc, racc;
        reset = rs; write = w; wdata = d; read = r; clear_errors = c;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            m_full  = (q.size() == DEPTH);
            m_empty = (q.size() == 0);
            wacc    = w && (!m_full || r);
            racc    = r && !m_empty;
            if (w && m_full && !r) m_ov = 1'b1;
            else if (c)            m_ov = 1'b0;
            if (r && m_empty)      m_un = 1'b1;
            else if (c)            m_un = 1'b0;
            if (racc) void'(q.pop_front());
            if (wacc) q.push_back(d);
        end
        #1;
        reset = 1'b0; write = 1'b0; read = 1'b0; clear_errors = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 8'($urandom), 1'b1, 1'b0);
        n_total++; if (count !== 5'd0) $display("FAIL reset_count: got %0d exp 0", count); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b exp 1", empty); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL reset_full: got %b exp 0", full); else n_pass++;
        n_total++; if (rdata !== 8'h00) $display("FAIL reset_rdata: got %h exp 00", rdata); else n_pass++;
        n_total++; if ({overflow, underflow} !== 2'b00) $display("FAIL reset_sticky: got %b exp 00", {overflow, underflow}); else n_pass++;
        n_total++; if (almost_full !== 1'b0) $display("FAIL reset_af: got %b exp 0", almost_full); else n_pass++;
        n_total++; if (almost_empty !== WM) $display("FAIL reset_ae: got %b exp %b", almost_empty, WM); else n_pass++;
    endtask

    task automatic test_fill_order();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
            if (i == 0) begin
                n_total++; if (empty !== 1'b0) $display("FAIL fill_first_empty: got %b exp 0", empty); else n_pass++;
                n_total++; if (rdata !== 8'h11) $display("FAIL fill_first_rdata: got %h exp 11", rdata); else n_pass++;
            end
        end
        n_total++; if (count !== 5'd8) $display("FAIL fill_count: got %0d exp 8", count); else n_pass++;
        n_total++; if (rdata !== 8'h11) $display("FAIL fill_rdata: got %h exp 11", rdata); else n_pass++;
        n_total++; if (almost_empty !== m_ae()) $display("FAIL fill_ae: got %b exp %b", almost_empty, m_ae()); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++; if (rdata !== 8'(8'h11 + i)) $display("FAIL fill_pop%0d: got %h exp %h", i, rdata, 8'(8'h11 + i)); else n_pass++;
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_total++; if (empty !== 1'b1) $display("FAIL fill_drained: got %b exp 1", empty); else n_pass++;
    endtask

    task automatic test_overflow();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 8'h9F)), 1'b0, 1'b0);
        n_total++; if ({full, count} !== {1'b1, 5'd16}) $display("FAIL ovf_full: got full=%b count=%0d exp full=1 count=16", full, count); else n_pass++;
        n_total++; if (almost_full !== m_af()) $display("FAIL ovf_af: got %b exp %b", almost_full, m_af()); else n_pass++;
        step(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b exp 1", overflow); else n_pass++;
        n_total++; if (count !== 5'd16) $display("FAIL ovf_count: got %0d exp 16", count); else n_pass++;
        step(1'b0, 1'b1, 8'hAB, 1'b0, 1'b1);
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_set_beats_clear: got %b exp 1", overflow); else n_pass++;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b exp 0", overflow); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            n_total++; if (rdata !== m_head() || rdata == 8'hAA || rdata == 8'hAB)
                $display("FAIL ovf_pop%0d: got %h exp %h", i, rdata, m_head()); else n_pass++;
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_total++; if ({empty, rdata} !== {1'b1, 8'h00}) $display("FAIL ovf_drained: got empty=%b rdata=%h exp empty=1 rdata=00", empty, rdata); else n_pass++;
    endtask

    task automatic test_full_rw();
        logic [DW-1:0] last;
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        n_total++; if ({full, count} !== {1'b1, 5'd16}) $display("FAIL fullrw_count: got full=%b count=%0d exp full=1 count=16", full, count); else n_pass++;
        n_total++; if (rdata !== 8'hC1) $display("FAIL fullrw_head: got %h exp c1", rdata); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL fullrw_ovf: got %b exp 0", overflow); else n_pass++;
        last = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            n_total++; if (rdata !== m_head()) $display("FAIL fullrw_pop%0d: got %h exp %h", i, rdata, m_head()); else n_pass++;
            last = rdata;
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_total++; if (last !== 8'h55) $display("FAIL fullrw_last: got %h exp 55", last); else n_pass++;
    endtask

    task automatic test_empty_rw();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
        n_total++; if (underflow !== 1'b1) $display("FAIL emptyrw_unf: got %b exp 1", underflow); else n_pass++;
        n_total++; if (count !== 5'd1) $display("FAIL emptyrw_count: got %0d exp 1", count); else n_pass++;
        n_total++; if (rdata !== 8'h3C) $display("FAIL emptyrw_rdata: got %h exp 3c", rdata); else n_pass++;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        n_total++; if (underflow !== 1'b0) $display("FAIL emptyrw_clear: got %b exp 0", underflow); else n_pass++;
    endtask

    task automatic test_random_wrap();
        logic [DW-1:0] base;
        logic          w, r, acc;
        int            sent, got, cyc;
        base = 8'($urandom);
        sent = 0; got = 0; cyc = 0;
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        while (got < 40 && cyc < 2000) begin
            w   = (sent < 40) && ($urandom_range(0, 1) == 1);
            r   = ($urandom_range(0, 1) == 1);
            acc = w && (q.size() < DEPTH || r);
            n_total++; if (rdata !== m_head()) $display("FAIL rand_head c%0d: got %h exp %h", cyc, rdata, m_head()); else n_pass++;
            if (r && q.size() > 0) begin
                n_total++; if (rdata !== 8'(base + got)) $display("FAIL rand_order #%0d: got %h exp %h", got, rdata, 8'(base + got)); else n_pass++;
                got++;
            end
            step(1'b0, w, 8'(base + sent), r, 1'b0);
            if (acc) sent++;
            n_total++; if (count !== 5'(q.size()) || count > 5'd16)
                $display("FAIL rand_count c%0d: got %0d exp %0d", cyc, count, q.size()); else n_pass++;
            n_total++; if ({empty, full} !== {q.size() == 0, q.size() == DEPTH})
                $display("FAIL rand_flags c%0d: got %b%b exp %b%b", cyc, empty, full, q.size() == 0, q.size() == DEPTH); else n_pass++;
            cyc++;
        end
        n_total++; if (got != 40) $display("FAIL rand_timeout: got %0d pops exp 40", got); else n_pass++;
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        n_total++; if ({count, underflow} !== {5'd5, 1'b1}) $display("FAIL mid_pre: got count=%0d unf=%b exp count=5 unf=1", count, underflow); else n_pass++;
        step(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
        n_total++; if ({count, empty, full} !== {5'd0, 1'b1, 1'b0}) $display("FAIL mid_reset: got count=%0d empty=%b full=%b exp 0 1 0", count, empty, full); else n_pass++;
        n_total++; if ({overflow, underflow, almost_full} !== 3'b000) $display("FAIL mid_flags: got %b exp 000", {overflow, underflow, almost_full}); else n_pass++;
    endtask

    task automatic test_watermark();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < AF; i++) begin
            step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
            n_total++; if (almost_full !== m_af()) $display("FAIL wm_af w%0d: got %b exp %b", i + 1, almost_full, m_af()); else n_pass++;
            n_total++; if (almost_empty !== m_ae()) $display("FAIL wm_ae w%0d: got %b exp %b", i + 1, almost_empty, m_ae()); else n_pass++;
        end
        n_total++; if (almost_full !== WM) $display("FAIL wm_af14: got %b exp %b", almost_full, WM); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill_order();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_random_wrap();
        test_reset_mid();
        test_watermark();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Synchronous transmit FIFO that buffers bytes from the host/bus side ahead of the UART transmit controller. It supplies the empty/full status that the controller uses to start frames. Its head word is presented first-word-fall-through, so the controller's load strobe captures the byte and pops it in the same cycle. Overflow and underflow errors are kept in sticky flags for the register block.

Parameters:
DATA_WIDTH, 8, width of one stored character
DEPTH, 16, number of entries; power of two, minimum 2
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (watermark feature only)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (watermark feature only)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
write  input  1  push request, one entry per cycle when high
wdata  input  DATA_WIDTH  data pushed on an accepted write
read  input  1  pop request; driven by the controller's load_TX_shift_reg
rdata  output  DATA_WIDTH  head entry, valid whenever empty=0
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds DEPTH entries
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
almost_full  output  1  watermark flag
almost_empty  output  1  watermark flag
overflow  output  1  sticky: a write was dropped
underflow  output  1  sticky: a read hit an empty FIFO
clear_errors  input  1  clears overflow/underflow

Behaviour:
- Reset, sampled at the clk edge: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, underflow=0, almost_full=0, almost_empty=1 (feature on) or 0 (feature off), rdata=0.
- Reset has priority over all other inputs. A reset mid-traffic discards all contents. Storage array is not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- empty, full and count are registered and derived from next-state count, with no combinational path from write/read.
- Accepted write = write & (~full | read). Accepted read = read & ~empty.
- Write when full without read: data dropped; count, pointers and contents unchanged; overflow<=1.
- Read when empty: ignored; underflow<=1. An empty FIFO receiving read and write together accepts the write only, with count 0->1.
- Read and write together when full: both accepted; count stays DEPTH; new data stored at the freed slot.
- Read and write together with 0<count<DEPTH: both accepted; count unchanged.
- count: +1 on write only, -1 on read only, unchanged otherwise.
- rdata = mem[rd_ptr] when empty=0, forced 0 when empty=1 (combinational read of registered pointer).
- Latency: a word written in cycle N appears on rdata and clears empty in cycle N+1.
- Pop takes effect at the clk edge; the next word is on rdata the following cycle.
- Sticky flags: set has priority over clear_errors in the same cycle; otherwise clear_errors drives both to 0 next cycle.
- Data ordering is strictly first in, first out; no data is reordered or duplicated across pointer wrap.

Optional Feature:
UART_TX_FIFO_WATERMARK_EN
- Defined: almost_full and almost_empty are registered compares of next-state count against AF_LEVEL and AE_LEVEL.
- Not defined: almost_full and almost_empty are tied to 0, the compare logic is absent, and AF_LEVEL/AE_LEVEL are unused. Ports remain present.

Test Plan:
- Reset, then write 0x11..0x18 on consecutive cycles with DEPTH=16 -> count=8, empty=0 one cycle after the first write, rdata=0x11.
- Write 16 bytes, then write 0xAA with read=0 -> full=1, count=16, overflow=1, 0xAA absent; 16 pops return original order, then empty=1, rdata=0.
- When full, hold write=1 with wdata=0x55 and read=1 for one cycle -> count stays 16, head advances, 0x55 appears as the last pop.
- When empty, assert read=1 and write=1 with wdata=0x3C -> underflow=1, count=1, rdata=0x3C next cycle. Then clear_errors=1 -> underflow=0.
- Push and pop 40 bytes with an incrementing pattern at a random 50% rate, forcing pointer wrap -> output sequence identical to input, count never exceeds 16.
- Reset asserted with count=5 -> next cycle count=0, empty=1, flags 0. With UART_TX_FIFO_WATERMARK_EN and AF_LEVEL=14, 14 writes -> almost_full=1 on the cycle after the 14th write.
